riscv_dmem_responder: RTL
=========================

Name: riscv_dmem_responder

Overview:
- Target-side responder for the core's data-memory request interface (req/we/adr/d/size in; ack/q/misaligned/page_fault out).
- Accepts one load or store at a time and checks alignment and address window.
- Drives a single-port synchronous on-chip SRAM with byte enables.
- Returns a one-cycle acknowledge with read data or a fault flag. Sits between the core's load/store unit and the tightly-coupled data RAM.

Parameters:
XLEN, 32, data/address width; 32 or 64
ADR_BITS, 12, SRAM word-address width (depth = 2**ADR_BITS words of XLEN bits)
BASE_ADR, 'h0, byte address of SRAM word 0; must be aligned to window size
WAIT_STATES, 0, extra idle cycles inserted after SRAM access (0..15)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
dmem_req  input  1  request; sampled only in IDLE
dmem_we  input  1  1=store, 0=load
dmem_adr  input  XLEN  byte address
dmem_d  input  XLEN  store data, already lane-shifted by initiator
dmem_size  input  biu_size_t  BYTE/HWORD/WORD/DWORD/UNDEF_SIZE
dmem_ack  output  1  one-cycle completion pulse
dmem_q  output  XLEN  raw SRAM word for loads; 0 for stores/faults
dmem_misaligned  output  1  valid with ack
dmem_page_fault  output  1  valid with ack; address outside window
sram_ce  output  1  SRAM chip enable
sram_we  output  1  SRAM write enable
sram_be  output  XLEN/8  byte enables
sram_adr  output  ADR_BITS  word address
sram_d  output  XLEN  write data
sram_q  input  XLEN  read data, valid cycle after sram_ce

Behaviour:
- Reset rstn, asynchronous, active-low; clock clk. All outputs registered. Reset drives FSM=IDLE and all outputs 0; wait counter 0.
- FSM states: IDLE, ACCESS, CAPTURE, WAIT, RESP.
- IDLE, req=1 in cycle T: latch we/adr/d/size at end of T.
  - Fault → RESP: ack=1 in T+1 with flag; no SRAM cycle, q=0.
  - Else → ACCESS.
- Fault priority: misaligned > page_fault.
- misaligned conditions:
  - HWORD with adr[0]=1.
  - WORD with adr[1:0]≠0.
  - DWORD with adr[2:0]≠0, only when XLEN=64.
  - DWORD when XLEN=32.
  - UNDEF_SIZE.
- page_fault: adr-BASE_ADR ≥ (XLEN/8)<<ADR_BITS, unsigned, including wrap below BASE_ADR.
- ACCESS (cycle T+1):
  - sram_ce=1, sram_we=we.
  - sram_adr=(adr-BASE_ADR)>>log2(XLEN/8).
  - sram_d=d.
  - sram_be = size mask (BYTE 1, HWORD 3, WORD 'hF, DWORD 'hFF) << adr byte-offset.
  - Next state: CAPTURE.
- CAPTURE (T+2): load data register from sram_q (loads only); sram_ce=0. Next state: WAIT if WAIT_STATES>0, else RESP.
- WAIT: count WAIT_STATES cycles, then RESP.
- RESP: ack=1 for exactly one cycle. Success ack at T+3+WAIT_STATES; q=captured word for loads, 0 for stores. Then IDLE.
- Protocol:
  - req ignored outside IDLE.
  - Initiator holds req until ack.
  - req high in the cycle after ack is a new request; back-to-back throughput is one access per 4+WAIT_STATES cycles.
- sram_ce/sram_we/sram_be are 0 in every state except ACCESS.
- Reset mid-operation: FSM to IDLE immediately, sram_ce/ack drop asynchronously, pending access discarded (store may or may not have been written if reset lands in ACCESS).

Decomposition:
- biu_size_t and size encodings stay in the existing shared core package.
- FSM state enum is local.
- One combinational sub-module, riscv_dmem_chk: inputs adr/size, outputs misaligned, page_fault, be, word address.

Test Plan:
- LW adr=BASE+'h10, sram_q='hDEADBEEF, WAIT_STATES=0 → sram_ce at T+1 with sram_adr=4, be='hF; ack at T+3 with q='hDEADBEEF, flags 0.
- SB adr=BASE+'h7, d='h55000000 → sram_be='h8, sram_we=1, sram_adr=1; ack at T+3, q=0.
- LH adr=BASE+'h3 → ack at T+1 with misaligned=1, no sram_ce pulse.
- LW adr=BASE+(4<<ADR_BITS) → ack at T+1 with page_fault=1.
- WAIT_STATES=3, req held high continuously → acks at T+6, T+13, T+20; req toggling mid-access ignored.
- rstn low during CAPTURE → ack/sram_ce 0 asynchronously; after release, a new LW completes normally.

Source files
------------

// File: rtl/riscv_dmem_responder_pkg.sv
// Shared core definitions used by the data-memory responder.
//   biu_size_t : access size encoding driven by the load/store unit
//   WAIT_CNT_W : width of the post-access wait-state counter (0..15 waits)
package riscv_dmem_responder_pkg;

    typedef enum logic [2:0] {
        BYTE       = 3'd0,
        HWORD      = 3'd1,
        WORD       = 3'd2,
        DWORD      = 3'd3,
        UNDEF_SIZE = 3'd7
    } biu_size_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/riscv_dmem_chk.sv
// Combinational request checker for the data-memory responder.
// Inputs : adr_i (byte address), size_i (access size)
// Outputs: misaligned_o, page_fault_o (address outside the SRAM window),
//          be_o (byte enables within the SRAM word), wadr_o (SRAM word address)
module riscv_dmem_chk
    import riscv_dmem_responder_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ADR_BITS = 12,
    parameter logic [XLEN-1:0] BASE_ADR = '0
) (
    input  logic [XLEN-1:0]     adr_i,
    input  biu_size_t           size_i,
    output logic                misaligned_o,
    output logic                page_fault_o,
    output logic [XLEN/8-1:0]   be_o,
    output logic [ADR_BITS-1:0] wadr_o
);
    localparam int BEW  = XLEN / 8;
    localparam int OFFW = $clog2(BEW);
    // Window size in bytes, one bit wider so it cannot overflow.
    localparam logic [XLEN:0] WIN = (XLEN+1)'(BEW) << ADR_BITS;

    logic [XLEN-1:0] off;
    logic [BEW-1:0]  mask;

    // Subtraction wraps, so addresses below BASE_ADR land far above the window.
    assign off          = adr_i - BASE_ADR;
    assign page_fault_o = {1'b0, off} >= WIN;
    assign wadr_o       = off[OFFW +: ADR_BITS];
    assign be_o         = mask << adr_i[OFFW-1:0];

    always_comb begin
        mask         = '0;
        misaligned_o = 1'b1;
        case (size_i)
            BYTE:  begin mask = BEW'(1);     misaligned_o = 1'b0;          end
            HWORD: begin mask = BEW'(3);     misaligned_o = adr_i[0];      end
            WORD:  begin mask = BEW'(4'hF);  misaligned_o = |adr_i[1:0];   end
            // Doubleword accesses only exist on a 64-bit datapath.
            DWORD: begin mask = BEW'(8'hFF); misaligned_o = (XLEN == 64) ? |adr_i[2:0] : 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder between the load/store unit and the tightly-coupled
// data SRAM. One access in flight; faults are answered without an SRAM cycle.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   dmem_req_i/we_i/adr_i/d_i/size_i  request from the core (sampled in IDLE)
//   dmem_ack_o/q_o                    one-cycle completion pulse and load data
//   dmem_misaligned_o/page_fault_o    fault flags, valid with ack
//   sram_ce_o/we_o/be_o/adr_o/d_o     synchronous SRAM command
//   sram_q_i                          SRAM read data, valid cycle after ce
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              ADR_BITS    = 12,
    parameter logic [XLEN-1:0] BASE_ADR    = '0,
    parameter int              WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                dmem_req_i,
    input  logic                dmem_we_i,
    input  logic [XLEN-1:0]     dmem_adr_i,
    input  logic [XLEN-1:0]     dmem_d_i,
    input  biu_size_t           dmem_size_i,
    output logic                dmem_ack_o,
    output logic [XLEN-1:0]     dmem_q_o,
    output logic                dmem_misaligned_o,
    output logic                dmem_page_fault_o,
    output logic                sram_ce_o,
    output logic                sram_we_o,
    output logic [XLEN/8-1:0]   sram_be_o,
    output logic [ADR_BITS-1:0] sram_adr_o,
    output logic [XLEN-1:0]     sram_d_o,
    input  logic [XLEN-1:0]     sram_q_i
);
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ack_q, ack_d, mis_q, mis_d, pf_q, pf_d;
    logic [XLEN-1:0]       q_q, q_d;
    logic                  ce_q, ce_d, swe_q, swe_d;
    logic [XLEN/8-1:0]     be_q, be_d;
    logic [ADR_BITS-1:0]   sadr_q, sadr_d;
    logic [XLEN-1:0]       sd_q, sd_d;

    logic                  chk_mis, chk_pf;
    logic [XLEN/8-1:0]     chk_be;
    logic [ADR_BITS-1:0]   chk_wadr;

    riscv_dmem_chk #(.XLEN(XLEN), .ADR_BITS(ADR_BITS), .BASE_ADR(BASE_ADR)) u_chk (
        .adr_i        (dmem_adr_i),
        .size_i       (dmem_size_i),
        .misaligned_o (chk_mis),
        .page_fault_o (chk_pf),
        .be_o         (chk_be),
        .wadr_o       (chk_wadr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            mis_q   <= 1'b0;
            pf_q    <= 1'b0;
            q_q     <= '0;
            ce_q    <= 1'b0;
            swe_q   <= 1'b0;
            be_q    <= '0;
            sadr_q  <= '0;
            sd_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            mis_q   <= mis_d;
            pf_q    <= pf_d;
            q_q     <= q_d;
            ce_q    <= ce_d;
            swe_q   <= swe_d;
            be_q    <= be_d;
            sadr_q  <= sadr_d;
            sd_q    <= sd_d;
        end
    end

    // Outputs are registered, so each branch computes what the outputs must
    // show in the state being entered.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        mis_d   = 1'b0;
        pf_d    = 1'b0;
        q_d     = '0;
        ce_d    = 1'b0;
        swe_d   = 1'b0;
        be_d    = '0;
        sadr_d  = sadr_q;
        sd_d    = sd_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_req_i) begin
                    we_d = dmem_we_i;
                    if (chk_mis || chk_pf) begin
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                        mis_d   = chk_mis;
                        pf_d    = chk_pf & ~chk_mis;
                    end else begin
                        // Address and data go straight into the SRAM command
                        // registers; they double as the request latch.
                        state_d = S_ACCESS;
                        ce_d    = 1'b1;
                        swe_d   = dmem_we_i;
                        be_d    = chk_be;
                        sadr_d  = chk_wadr;
                        sd_d    = dmem_d_i;
                    end
                end
            end
            S_ACCESS: state_d = S_CAPTURE;
            S_CAPTURE: begin
                data_d = we_q ? '0 : sram_q_i;
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                end else begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                    q_d     = we_q ? '0 : sram_q_i;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                    q_d     = data_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign dmem_ack_o        = ack_q;
    assign dmem_q_o          = q_q;
    assign dmem_misaligned_o = mis_q;
    assign dmem_page_fault_o = pf_q;
    assign sram_ce_o         = ce_q;
    assign sram_we_o         = swe_q;
    assign sram_be_o         = be_q;
    assign sram_adr_o        = sadr_q;
    assign sram_d_o          = sd_q;

endmodule
